vga_pixel_stage: RTL and testbench
==================================

Name: vga_pixel_stage

Overview:
- Parametrised successor to the VGA colour-assign stage.
- Decides per pixel whether the h/v counters are inside the display window and selects the RGB output: pixel data, border, solid fill, black or underrun marker.
- Delays colour by a configurable pipeline depth so it aligns with the sync outputs of the VGA controller.
- Detects upstream data underrun and provides frame and line markers.
- Sits between the pixel source (line buffer/RAM) and the VGA DAC pins.

Parameters:
- COLOR_WIDTH, 4, bits per colour channel.
- DATA_WIDTH, 3*COLOR_WIDTH, packed pixel width: Red = [CW-1:0], Green = [2CW-1:CW], Blue = [3CW-1:2CW].
- REZ_MAX_WIDTH, 11, width of counters and margins.
- PIPE_DEPTH, 2, input-to-output colour latency in clocks; legal range 1..8.
- BORDER_PX, 4, border thickness in pixels, applied on all four window edges.
- UCNT_WIDTH, 16, width of the underrun counter.

Ports:
- Clk  in  1  pixel clock.
- Rst_n  in  1  asynchronous, active-low reset.
- Count_h  in  REZ_MAX_WIDTH  horizontal pixel counter.
- Count_v  in  REZ_MAX_WIDTH  vertical line counter.
- H_left_margin, H_right_margin  in  REZ_MAX_WIDTH  first/last active column, inclusive.
- V_left_margin, V_right_margin  in  REZ_MAX_WIDTH  first/last active line, inclusive.
- Data  in  DATA_WIDTH  pixel data for current counters.
- Data_valid  in  1  Data is valid this cycle.
- Pix_req  out  1  combinational; counters are inside the window; upstream must present Data in the same cycle.
- Mode  in  2  0 = data, 1 = data with border, 2 = solid fill, 3 = blank.
- Border_color  in  DATA_WIDTH  colour for the border in mode 1 and for the fill in mode 2.
- Clr_flag  in  1  clears Underrun_flag and Underrun_cnt.
- Red, Green, Blue  out  COLOR_WIDTH each  colour outputs.
- Frame_start  out  1  one-cycle pulse, aligned with the output colour.
- Line_end  out  1  one-cycle pulse, aligned with the output colour.
- Underrun_flag  out  1  sticky.
- Underrun_cnt  out  UCNT_WIDTH  saturating count of underrun pixels.

Behaviour:
- Window test: In_win = (H_left <= Count_h <= H_right) and (V_left <= Count_v <= V_right). Comparisons are unsigned. If left > right on either axis, the window is empty and In_win is never asserted. Pix_req = In_win.
- Border test: Border = In_win and (Count_h < H_left+BORDER_PX or Count_h > H_right-BORDER_PX or Count_v < V_left+BORDER_PX or Count_v > V_right-BORDER_PX). Arithmetic is REZ_MAX_WIDTH+1 bits so there is no wrap. A window narrower than 2*BORDER_PX is entirely border.
- Colour select, evaluated on the inputs of cycle t:
  - Not In_win: 0.
  - Mode 3: 0.
  - Mode 2: Border_color.
  - Mode 1 and Border: Border_color.
  - Otherwise Data.
  - In modes 0 and 1, an in-window non-border pixel with Data_valid = 0 is an underrun: output {R = all ones, G = 0, B = 0}.
  - Underruns are not counted in modes 2 and 3, or on border pixels in mode 1.
- Latency: the selected colour appears on Red/Green/Blue at t+PIPE_DEPTH through a shift register. There is no bypass for PIPE_DEPTH = 1 (registered output only).
- Frame_start: asserted at t+PIPE_DEPTH when Count_h == H_left and Count_v == V_left at t.
- Line_end: asserted at t+PIPE_DEPTH when In_win and Count_h == H_right at t.
- Shadowing:
  - Mode and Border_color are loaded into shadow registers only in the cycle where the Frame_start condition is true at t (pre-pipeline). Changes mid-frame take effect from the next frame.
  - Colour select uses the shadow values, never the live inputs.
- Underrun flag and counter:
  - Underrun_flag is set at t+1 after an underrun pixel at t.
  - Underrun_cnt increments at t+1 and saturates at all ones.
  - Clr_flag clears both at the next edge. If Clr_flag and an underrun occur in the same cycle, the flag ends at 1 and the count ends at 1.
- Reset (Rst_n low, asynchronous):
  - Pipeline, colour outputs, Frame_start, Line_end, Underrun_flag, Underrun_cnt and Mode shadow all go to 0. Border shadow goes to 0.
  - Pix_req still follows the inputs combinationally.
  - Outputs stay 0 for PIPE_DEPTH cycles after reset release while the pipeline refills with computed values.
  - Reset mid-frame: the first shadow load occurs at the next Frame_start; until then mode 0 is in effect.

Optional Feature:
- Macro: VGA_PIXEL_TEST_PATTERN_EN.
- When defined, Mode 3 produces 8 vertical colour bars instead of black:
  - Bar index = ((Count_h - H_left) * 8) / (H_right - H_left + 1), evaluated per pixel.
  - Bar colour: each channel all-ones or 0, from index bits {B,G,R} = index[2:0].
  - Data_valid is ignored and no underrun is counted.
- When not defined, Mode 3 is blank (all zeros) and no divider logic is synthesised.

Test Plan:
- Reset/latency: PIPE_DEPTH = 2, window 144..783 x 35..514, Mode 0, Data = 12'hABC valid; Count_h = 144, Count_v = 35 at t -> R = C, G = B, B = A at t+2; Frame_start pulse at t+2; outputs 0 during reset.
- Boundaries: Count_h = 143 -> 0 and Pix_req = 0; Count_h = 783 -> data with Line_end = 1; Count_h = 784 -> 0; Count_v = 515 -> 0; swapped margins (H_left = 800, H_right = 100) -> Pix_req never asserted.
- Border/shadow: Mode set to 1 mid-frame with Border_color = 12'hFFF -> no change until the next Frame_start; afterwards Count_h = 146 -> FFF and Count_h = 148 -> Data.
- Underrun: Mode 0, Data_valid = 0 for 3 in-window pixels -> output R = F, G = 0, B = 0; Underrun_cnt = 3; flag = 1; Clr_flag coincident with a 4th underrun -> cnt = 1, flag = 1; UCNT_WIDTH = 4 with 20 underruns -> cnt = 15.
- Mode 2/3: Mode 2 -> every in-window pixel = Border_color regardless of Data_valid and count unchanged; Mode 3 -> 0; with VGA_PIXEL_TEST_PATTERN_EN, a 640-wide window gives column 80 -> bar 1 (R = F, G = 0, B = 0) and column 639 -> bar 7 (all F).

Source files
------------

// File: rtl/vga_pixel_stage.sv
// vga_pixel_stage: per-pixel window/border decision and RGB select for a VGA
// output path. The selected colour, Frame_start and Line_end are delayed by
// PIPE_DEPTH clocks to line up with the controller's sync outputs.
// Mode and Border_color are shadowed at frame start so mid-frame changes take
// effect on the next frame. Upstream underruns are flagged and counted.
// Optional build macro VGA_PIXEL_TEST_PATTERN_EN: mode 3 shows eight vertical
// colour bars instead of black.
module vga_pixel_stage #(
    parameter int COLOR_WIDTH   = 4,
    parameter int DATA_WIDTH    = 3 * COLOR_WIDTH,
    parameter int REZ_MAX_WIDTH = 11,
    parameter int PIPE_DEPTH    = 2,
    parameter int BORDER_PX     = 4,
    parameter int UCNT_WIDTH    = 16
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [REZ_MAX_WIDTH-1:0] Count_h,
    input  logic [REZ_MAX_WIDTH-1:0] Count_v,
    input  logic [REZ_MAX_WIDTH-1:0] H_left_margin,
    input  logic [REZ_MAX_WIDTH-1:0] H_right_margin,
    input  logic [REZ_MAX_WIDTH-1:0] V_left_margin,
    input  logic [REZ_MAX_WIDTH-1:0] V_right_margin,
    input  logic [DATA_WIDTH-1:0]    Data,
    input  logic                     Data_valid,
    output logic                     Pix_req,
    input  logic [1:0]               Mode,
    input  logic [DATA_WIDTH-1:0]    Border_color,
    input  logic                     Clr_flag,
    output logic [COLOR_WIDTH-1:0]   Red,
    output logic [COLOR_WIDTH-1:0]   Green,
    output logic [COLOR_WIDTH-1:0]   Blue,
    output logic                     Frame_start,
    output logic                     Line_end,
    output logic                     Underrun_flag,
    output logic [UCNT_WIDTH-1:0]    Underrun_cnt
);

    // One extra bit so margin +/- border arithmetic never wraps.
    localparam int XW = REZ_MAX_WIDTH + 1;
    localparam logic [XW-1:0] BPX = XW'(BORDER_PX);
    // Underrun marker: red channel all ones, green and blue zero.
    localparam logic [DATA_WIDTH-1:0] UND_COL =
        {{(DATA_WIDTH-COLOR_WIDTH){1'b0}}, {COLOR_WIDTH{1'b1}}};

    logic [XW-1:0] h_x, v_x, hl_x, hr_x, vl_x, vr_x;
    logic          in_win;
    logic          border;
    logic          frame_cond;
    logic          line_cond;
    logic          und_now;
    logic [DATA_WIDTH-1:0] col_d;

    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] bcol_q;

    logic [DATA_WIDTH-1:0] col_q [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] fs_q;
    logic [PIPE_DEPTH-1:0] le_q;

    logic                  uflag_d, uflag_q;
    logic [UCNT_WIDTH-1:0] ucnt_d, ucnt_q;

    assign h_x  = {1'b0, Count_h};
    assign v_x  = {1'b0, Count_v};
    assign hl_x = {1'b0, H_left_margin};
    assign hr_x = {1'b0, H_right_margin};
    assign vl_x = {1'b0, V_left_margin};
    assign vr_x = {1'b0, V_right_margin};

    // An inverted margin pair (left > right) makes the range test fail, so the window is empty.
    assign in_win = (Count_h >= H_left_margin) && (Count_h <= H_right_margin) &&
                    (Count_v >= V_left_margin) && (Count_v <= V_right_margin);
    assign Pix_req = in_win;

    // "x > right - B" is written as "x + B > right" so a tiny window cannot underflow.
    assign border = in_win &&
                    ((h_x < hl_x + BPX) || (h_x + BPX > hr_x) ||
                     (v_x < vl_x + BPX) || (v_x + BPX > vr_x));

    assign frame_cond = (Count_h == H_left_margin) && (Count_v == V_left_margin);
    assign line_cond  = in_win && (Count_h == H_right_margin);

`ifdef VGA_PIXEL_TEST_PATTERN_EN
    logic [XW+2:0]         pat_num;
    logic [XW+2:0]         pat_den;
    logic [2:0]            bar_idx;
    logic [DATA_WIDTH-1:0] pat_col;

    assign pat_num = {h_x - hl_x, 3'b000};
    assign pat_den = {2'b00, hr_x - hl_x + XW'(1)};
    assign bar_idx = (pat_den == '0) ? 3'd0 : 3'(pat_num / pat_den);
    assign pat_col = {{COLOR_WIDTH{bar_idx[2]}}, {COLOR_WIDTH{bar_idx[1]}},
                      {COLOR_WIDTH{bar_idx[0]}}};
`endif

    // Colour select from the shadowed mode/colour; flags underruns where pixel data is required.
    always_comb begin
        col_d   = '0;
        und_now = 1'b0;
        if (in_win) begin
            case (mode_q)
                2'd0, 2'd1: begin
                    if ((mode_q == 2'd1) && border) begin
                        col_d = bcol_q;
                    end else if (Data_valid) begin
                        col_d = Data;
                    end else begin
                        col_d   = UND_COL;
                        und_now = 1'b1;
                    end
                end
                2'd2: col_d = bcol_q;
                default: begin
`ifdef VGA_PIXEL_TEST_PATTERN_EN
                    col_d = pat_col;
`else
                    col_d = '0;
`endif
                end
            endcase
        end
    end

    // Shadow registers capture Mode and Border_color only at the frame-start pixel.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mode_q <= 2'd0;
            bcol_q <= '0;
        end else if (frame_cond) begin
            mode_q <= Mode;
            bcol_q <= Border_color;
        end
    end

    // Delay line aligning colour and markers with the sync outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                col_q[i] <= '0;
            end
            fs_q <= '0;
            le_q <= '0;
        end else begin
            col_q[0] <= col_d;
            fs_q[0]  <= frame_cond;
            le_q[0]  <= line_cond;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                col_q[i] <= col_q[i-1];
                fs_q[i]  <= fs_q[i-1];
                le_q[i]  <= le_q[i-1];
            end
        end
    end

    // Clear wins over the old state but not over an underrun in the same cycle.
    always_comb begin
        uflag_d = uflag_q;
        ucnt_d  = ucnt_q;
        if (Clr_flag) begin
            uflag_d = und_now;
            ucnt_d  = UCNT_WIDTH'(und_now);
        end else if (und_now) begin
            uflag_d = 1'b1;
            if (ucnt_q != '1) begin
                ucnt_d = ucnt_q + UCNT_WIDTH'(1);
            end
        end
    end

    // Sticky underrun flag and saturating counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            uflag_q <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            uflag_q <= uflag_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign Red           = col_q[PIPE_DEPTH-1][COLOR_WIDTH-1:0];
    assign Green         = col_q[PIPE_DEPTH-1][2*COLOR_WIDTH-1:COLOR_WIDTH];
    assign Blue          = col_q[PIPE_DEPTH-1][3*COLOR_WIDTH-1:2*COLOR_WIDTH];
    assign Frame_start   = fs_q[PIPE_DEPTH-1];
    assign Line_end      = le_q[PIPE_DEPTH-1];
    assign Underrun_flag = uflag_q;
    assign Underrun_cnt  = ucnt_q;

endmodule

// File: tb/tb_vga_pixel_stage.sv
// Directed testbench for vga_pixel_stage (PIPE_DEPTH = 2, 640x480 window at
// 144..783 x 35..514). A second instance with a 4-bit underrun counter shares
// the stimulus to exercise counter saturation.
module tb_vga_pixel_stage;

    localparam int CW = 4;
    localparam int DW = 12;
    localparam int RW = 11;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic [RW-1:0] Count_h, Count_v;
    logic [RW-1:0] H_left_margin, H_right_margin, V_left_margin, V_right_margin;
    logic [DW-1:0] Data, Border_color;
    logic          Data_valid, Clr_flag;
    logic [1:0]    Mode;

    logic          Pix_req, Frame_start, Line_end, Underrun_flag;
    logic [CW-1:0] Red, Green, Blue;
    logic [15:0]   Underrun_cnt;

    logic          pix_req4, fs4, le4, uflag4;
    logic [CW-1:0] red4, green4, blue4;
    logic [3:0]    ucnt4;

    int n_checks = 0;
    int n_err    = 0;

    always #5 Clk = ~Clk;

    vga_pixel_stage #(.COLOR_WIDTH(CW), .REZ_MAX_WIDTH(RW), .PIPE_DEPTH(2),
                      .BORDER_PX(4), .UCNT_WIDTH(16)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .Count_h(Count_h), .Count_v(Count_v),
        .H_left_margin(H_left_margin), .H_right_margin(H_right_margin),
        .V_left_margin(V_left_margin), .V_right_margin(V_right_margin),
        .Data(Data), .Data_valid(Data_valid), .Pix_req(Pix_req), .Mode(Mode),
        .Border_color(Border_color), .Clr_flag(Clr_flag),
        .Red(Red), .Green(Green), .Blue(Blue),
        .Frame_start(Frame_start), .Line_end(Line_end),
        .Underrun_flag(Underrun_flag), .Underrun_cnt(Underrun_cnt));

    vga_pixel_stage #(.COLOR_WIDTH(CW), .REZ_MAX_WIDTH(RW), .PIPE_DEPTH(2),
                      .BORDER_PX(4), .UCNT_WIDTH(4)) u_dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .Count_h(Count_h), .Count_v(Count_v),
        .H_left_margin(H_left_margin), .H_right_margin(H_right_margin),
        .V_left_margin(V_left_margin), .V_right_margin(V_right_margin),
        .Data(Data), .Data_valid(Data_valid), .Pix_req(pix_req4), .Mode(Mode),
        .Border_color(Border_color), .Clr_flag(Clr_flag),
        .Red(red4), .Green(green4), .Blue(blue4),
        .Frame_start(fs4), .Line_end(le4),
        .Underrun_flag(uflag4), .Underrun_cnt(ucnt4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input int h, input int v, input logic vld);
        Count_h    = RW'(h);
        Count_v    = RW'(v);
        Data_valid = vld;
    endtask

    task automatic park();
        Count_h    = '0;
        Count_v    = '0;
        Data_valid = 1'b1;
        Clr_flag   = 1'b0;
    endtask

    // Present one pixel, then park the counters and look at the output two clocks later.
    task automatic pix1(input string tag, input int h, input int v, input logic vld,
                        input logic exp_req, input logic chk_rgb, input logic [11:0] exp_rgb,
                        input logic exp_fs, input logic exp_le);
        drive(h, v, vld);
        #1;
        chk({tag, "_req"}, 32'(Pix_req), 32'(exp_req));
        tick();
        park();
        tick();
        if (chk_rgb) chk({tag, "_rgb"}, 32'({Blue, Green, Red}), 32'(exp_rgb));
        chk({tag, "_fs"}, 32'(Frame_start), 32'(exp_fs));
        chk({tag, "_le"}, 32'(Line_end), 32'(exp_le));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs[5];
        logic [11:0] exp80, exp639;
        hs = '{0, 100, 400, 800, 1000};

        // Reset: outputs held at zero, Pix_req stays combinational
        Rst_n          = 1'b0;
        H_left_margin  = 11'd144;
        H_right_margin = 11'd783;
        V_left_margin  = 11'd35;
        V_right_margin = 11'd514;
        Mode           = 2'd0;
        Border_color   = 12'h000;
        Data           = 12'hABC;
        Data_valid     = 1'b1;
        Clr_flag       = 1'b0;
        Count_h        = 11'd144;
        Count_v        = 11'd35;
        repeat (3) tick();
        chk("rst_rgb",   32'({Blue, Green, Red}), 32'h0);
        chk("rst_fs",    32'(Frame_start), 32'h0);
        chk("rst_flag",  32'(Underrun_flag), 32'h0);
        chk("rst_cnt",   32'(Underrun_cnt), 32'h0);
        chk("rst_req",   32'(Pix_req), 32'h1);
        park();
        Rst_n = 1'b1;

        // First pixel of the frame reaches the output after two clocks
        drive(144, 35, 1'b1);
        tick();
        chk("lat1_rgb", 32'({Blue, Green, Red}), 32'h0);
        chk("lat1_fs",  32'(Frame_start), 32'h0);
        park();
        tick();
        chk("lat2_rgb", 32'({Blue, Green, Red}), 32'hABC);
        chk("lat2_red", 32'(Red), 32'hC);
        chk("lat2_fs",  32'(Frame_start), 32'h1);
        tick();
        chk("fs_pulse", 32'(Frame_start), 32'h0);

        // Window boundaries
        pix1("h143", 143, 100, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
        pix1("h783", 783, 100, 1'b1, 1'b1, 1'b1, 12'hABC, 1'b0, 1'b1);
        pix1("h784", 784, 100, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
        pix1("v515", 400, 515, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
        pix1("v514", 400, 514, 1'b1, 1'b1, 1'b1, 12'hABC, 1'b0, 1'b0);

        // Swapped horizontal margins give an empty window
        H_left_margin  = 11'd800;
        H_right_margin = 11'd100;
        for (int i = 0; i < 5; i++) begin
            drive(hs[i], 100, 1'b1);
            #1;
            chk("swap_req", 32'(Pix_req), 32'h0);
        end
        park();
        H_left_margin  = 11'd144;
        H_right_margin = 11'd783;

        // Mode/border shadowing: mid-frame change waits for the next frame start
        Mode         = 2'd1;
        Border_color = 12'hFFF;
        pix1("shadow_hold", 146, 100, 1'b1, 1'b1, 1'b1, 12'hABC, 1'b0, 1'b0);
        pix1("frame2",      144, 35,  1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        Border_color = 12'h123;
        pix1("border146",   146, 100, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0);
        pix1("inner148",    148, 100, 1'b1, 1'b1, 1'b1, 12'hABC, 1'b0, 1'b0);
        pix1("inner779",    779, 100, 1'b1, 1'b1, 1'b1, 12'hABC, 1'b0, 1'b0);
        pix1("border780",   780, 100, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0);
        pix1("border_v38",  400, 38,  1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0);
        pix1("inner_v39",   400, 39,  1'b1, 1'b1, 1'b1, 12'hABC, 1'b0, 1'b0);
        pix1("border_inv",  146, 100, 1'b0, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0);
        chk("m1_border_nocount", 32'(Underrun_cnt), 32'h0);
        pix1("inner_inv",   400, 100, 1'b0, 1'b1, 1'b1, 12'h00F, 1'b0, 1'b0);
        chk("m1_inner_count", 32'(Underrun_cnt), 32'h1);
        Clr_flag = 1'b1;
        tick();
        Clr_flag = 1'b0;
        Mode         = 2'd0;
        Border_color = 12'h000;
        pix1("frame3",      144, 35,  1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0);

        // Underrun: three consecutive missing pixels
        chk("und0_cnt", 32'(Underrun_cnt), 32'h0);
        drive(300, 100, 1'b0);
        tick();
        drive(301, 100, 1'b0);
        tick();
        chk("und_rgb1", 32'({Blue, Green, Red}), 32'h00F);
        drive(302, 100, 1'b0);
        tick();
        chk("und_rgb2", 32'({Blue, Green, Red}), 32'h00F);
        park();
        tick();
        chk("und_rgb3", 32'({Blue, Green, Red}), 32'h00F);
        chk("und3_cnt",  32'(Underrun_cnt), 32'd3);
        chk("und3_flag", 32'(Underrun_flag), 32'h1);
        chk("und3_cnt4", 32'(ucnt4), 32'd3);

        // Clear coincident with an underrun keeps one
        drive(303, 100, 1'b0);
        Clr_flag = 1'b1;
        tick();
        park();
        chk("clr_und_cnt",  32'(Underrun_cnt), 32'd1);
        chk("clr_und_flag", 32'(Underrun_flag), 32'h1);
        Clr_flag = 1'b1;
        tick();
        Clr_flag = 1'b0;
        chk("clr_cnt",  32'(Underrun_cnt), 32'd0);
        chk("clr_flag", 32'(Underrun_flag), 32'h0);

        // Twenty underruns: 16-bit counter counts, 4-bit counter saturates
        for (int i = 0; i < 20; i++) begin
            drive(300 + i, 100, 1'b0);
            tick();
        end
        park();
        tick();
        chk("und20_cnt",  32'(Underrun_cnt), 32'd20);
        chk("und20_cnt4", 32'(ucnt4), 32'd15);
        chk("und20_flag", 32'(uflag4), 32'h1);
        Clr_flag = 1'b1;
        tick();
        Clr_flag = 1'b0;

        // Mode 2: solid fill regardless of Data_valid, nothing counted
        Mode         = 2'd2;
        Border_color = 12'h5A3;
        pix1("frame4", 144, 35,  1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        pix1("m2_inv", 400, 200, 1'b0, 1'b1, 1'b1, 12'h5A3, 1'b0, 1'b0);
        pix1("m2_v",   146, 100, 1'b1, 1'b1, 1'b1, 12'h5A3, 1'b0, 1'b0);
        pix1("m2_out", 100, 100, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
        chk("m2_nocount", 32'(Underrun_cnt), 32'h0);

        // Asynchronous reset mid-frame; mode 0 applies until the next frame start
        drive(400, 200, 1'b1);
        tick();
        tick();
        chk("pre_rst_rgb", 32'({Blue, Green, Red}), 32'h5A3);
        Rst_n = 1'b0;
        #1;
        chk("async_rst_rgb", 32'({Blue, Green, Red}), 32'h0);
        tick();
        Rst_n = 1'b1;
        tick();
        chk("rst_refill_rgb", 32'({Blue, Green, Red}), 32'h0);
        tick();
        chk("rst_mode0_rgb", 32'({Blue, Green, Red}), 32'hABC);
        park();

        // Mode 3: blank, or colour bars when the test pattern is built in
        Mode = 2'd3;
        pix1("frame5", 144, 35, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
`ifdef VGA_PIXEL_TEST_PATTERN_EN
        exp80  = 12'h00F;
        exp639 = 12'hFFF;
`else
        exp80  = 12'h000;
        exp639 = 12'h000;
`endif
        pix1("m3_c80",  224, 200, 1'b0, 1'b1, 1'b1, exp80,  1'b0, 1'b0);
        pix1("m3_c639", 783, 200, 1'b0, 1'b1, 1'b1, exp639, 1'b0, 1'b1);
        chk("m3_nocount", 32'(Underrun_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
